// File: rtl/cycle_step_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : cycle_step_sequencer
//  Description : T-state / M-cycle sequencer for the ControlUnit. Produces the
//                one-hot T-state and M-cycle index that every per-instruction
//                microcode block decodes. It ends an instruction when the
//                ORed end request arrives at T4 and latches the next opcode at
//                that point. It also handles memory stalls, an over-length
//                instruction watchdog and, optionally, HALT entry and exit.
//  Build macro : CYCLE_HALT_EN - when defined, builds the HALTED state
//                (i_Halt / i_Wake). When undefined, o_Halted is tied low.
//  Ports       :
//    i_Clk           system clock, rising edge
//    i_Reset         asynchronous active-high reset
//    i_Stall         freeze all state this cycle (memory wait)
//    i_Reset_Cycle   end-of-instruction request from the microcode blocks
//    i_Opcode_In     fetched opcode, latched when an end request is honoured
//    i_Halt          HALT request (CYCLE_HALT_EN only)
//    i_Wake          wake request, level (CYCLE_HALT_EN only)
//    o_Cycle_Step    one-hot T-state, 0000 while halted
//    o_M_Cycle       M-cycle index within the current instruction
//    o_Opcode        opcode of the executing instruction
//    o_Instr_Start   pulse on the first T-state of each instruction
//    o_Halted        high while in the HALTED state
//    o_Fault         sticky watchdog / protocol fault
//  Revision    : 1.0 - initial release
// ============================================================================
module cycle_step_sequencer #(
    parameter int MAX_M_CYCLES = 6,
    parameter int M_WIDTH      = 3
) (
    input  logic               i_Clk,
    input  logic               i_Reset,
    input  logic               i_Stall,
    input  logic               i_Reset_Cycle,
    input  logic [7:0]         i_Opcode_In,
    input  logic               i_Halt,
    input  logic               i_Wake,
    output logic [3:0]         o_Cycle_Step,
    output logic [M_WIDTH-1:0] o_M_Cycle,
    output logic [7:0]         o_Opcode,
    output logic               o_Instr_Start,
    output logic               o_Halted,
    output logic               o_Fault
);

    localparam logic [3:0]         c_STEP_T1   = 4'b0001;
    localparam logic [3:0]         c_STEP_NONE = 4'b0000;
    localparam logic [7:0]         c_OP_NOP    = 8'h00;
    // Last legal M-cycle index; wrapping out of T4 here trips the watchdog.
    localparam logic [M_WIDTH-1:0] c_M_LAST    = M_WIDTH'(MAX_M_CYCLES - 1);

    logic [3:0]         r_step;
    logic [M_WIDTH-1:0] r_m;
    logic [7:0]         r_opcode;
    logic               r_start;
    logic               r_fault;

    logic [3:0]         w_step_nxt;
    logic [M_WIDTH-1:0] w_m_nxt;
    logic [7:0]         w_opcode_nxt;
    logic               w_start_nxt;
    logic               w_fault_nxt;

`ifdef CYCLE_HALT_EN
    localparam logic [0:0] c_ST_RUN    = 1'b0;
    localparam logic [0:0] c_ST_HALTED = 1'b1;

    logic [0:0] r_state;
    logic [0:0] w_state_nxt;

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_state <= c_ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign o_Halted = (r_state == c_ST_HALTED);
`else
    // HALT support not built: consume the unused request inputs.
    logic w_unused_halt_inputs;
    assign w_unused_halt_inputs = i_Halt | i_Wake;
    assign o_Halted             = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_step   <= c_STEP_T1;
            r_m      <= '0;
            r_opcode <= c_OP_NOP;
            r_start  <= 1'b1;   // the NOP that follows reset counts as a start
            r_fault  <= 1'b0;
        end else begin
            r_step   <= w_step_nxt;
            r_m      <= w_m_nxt;
            r_opcode <= w_opcode_nxt;
            r_start  <= w_start_nxt;
            r_fault  <= w_fault_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic. Everything holds by default, which is exactly the
    // behaviour of a stalled cycle.
    // ------------------------------------------------------------------------
    always_comb begin
        w_step_nxt   = r_step;
        w_m_nxt      = r_m;
        w_opcode_nxt = r_opcode;
        w_start_nxt  = r_start;
        w_fault_nxt  = r_fault;
`ifdef CYCLE_HALT_EN
        w_state_nxt  = r_state;

        if (r_state == c_ST_HALTED) begin
            w_start_nxt = 1'b0;
            // Stall outranks wake; the opcode latched at HALT entry is kept.
            if (!i_Stall && i_Wake) begin
                w_state_nxt = c_ST_RUN;
                w_step_nxt  = c_STEP_T1;
                w_m_nxt     = '0;
                w_start_nxt = 1'b1;
            end
        end else
`endif
        if (!i_Stall) begin
            w_start_nxt = 1'b0;
            if (r_step[3]) begin
                if (i_Reset_Cycle) begin
                    // Honoured end request; it outranks the watchdog.
                    w_opcode_nxt = i_Opcode_In;
                    w_m_nxt      = '0;
`ifdef CYCLE_HALT_EN
                    if (i_Halt) begin
                        w_state_nxt = c_ST_HALTED;
                        w_step_nxt  = c_STEP_NONE;
                    end else
`endif
                    begin
                        w_step_nxt  = c_STEP_T1;
                        w_start_nxt = 1'b1;
                    end
                end else if (r_m == c_M_LAST) begin
                    // Instruction overran its longest legal length: abandon
                    // it and start the next fetched opcode.
                    w_step_nxt   = c_STEP_T1;
                    w_m_nxt      = '0;
                    w_opcode_nxt = i_Opcode_In;
                    w_start_nxt  = 1'b1;
                    w_fault_nxt  = 1'b1;
                end else begin
                    w_step_nxt = c_STEP_T1;
                    w_m_nxt    = r_m + 1'b1;
                end
            end else begin
                w_step_nxt = {r_step[2:0], 1'b0};
                // An end request is only legal at T4.
                if (i_Reset_Cycle) begin
                    w_fault_nxt = 1'b1;
                end
            end
        end
    end

    assign o_Cycle_Step  = r_step;
    assign o_M_Cycle     = r_m;
    assign o_Opcode      = r_opcode;
    // A stalled first T-state has not started yet; the pulse is shown on the
    // first cycle that actually executes.
    assign o_Instr_Start = r_start & ~i_Stall;
    assign o_Fault       = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_cycle_step_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cycle_step_sequencer
//  Description : Self-checking bench for cycle_step_sequencer. A behavioural
//                model tracks the T-state as an index 0..3, the M-cycle count
//                and the halt/fault flags, and every cycle is compared with it.
//                Honours CYCLE_HALT_EN the same way as the design.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cycle_step_sequencer;

    localparam int MAX_M = 6;
    localparam int MW    = 3;

    logic          clk = 1'b0;
    logic          i_Reset = 1'b1;
    logic          i_Stall = 1'b1;
    logic          i_Reset_Cycle = 1'b0;
    logic [7:0]    i_Opcode_In = 8'h00;
    logic          i_Halt = 1'b0;
    logic          i_Wake = 1'b0;
    logic [3:0]    o_Cycle_Step;
    logic [MW-1:0] o_M_Cycle;
    logic [7:0]    o_Opcode;
    logic          o_Instr_Start;
    logic          o_Halted;
    logic          o_Fault;

    cycle_step_sequencer #(
        .MAX_M_CYCLES (MAX_M),
        .M_WIDTH      (MW)
    ) u_dut (
        .i_Clk         (clk),
        .i_Reset       (i_Reset),
        .i_Stall       (i_Stall),
        .i_Reset_Cycle (i_Reset_Cycle),
        .i_Opcode_In   (i_Opcode_In),
        .i_Halt        (i_Halt),
        .i_Wake        (i_Wake),
        .o_Cycle_Step  (o_Cycle_Step),
        .o_M_Cycle     (o_M_Cycle),
        .o_Opcode      (o_Opcode),
        .o_Instr_Start (o_Instr_Start),
        .o_Halted      (o_Halted),
        .o_Fault       (o_Fault)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef CYCLE_HALT_EN
    localparam bit c_HALT_EN = 1'b1;
`else
    localparam bit c_HALT_EN = 1'b0;
`endif

    // Reference model state
    int         mdl_t;       // T-state index 0..3
    int         mdl_m;       // M-cycle count
    logic [7:0] mdl_op;
    bit         mdl_fault;
    bit         mdl_halted;
    bit         mdl_start;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mdl_t = 0; mdl_m = 0; mdl_op = 8'h00;
        mdl_fault = 0; mdl_halted = 0; mdl_start = 1;
    endtask

    task automatic compare_all(input bit stall);
        logic [31:0] exp_step;
        exp_step = mdl_halted ? 32'd0 : (32'd1 << mdl_t);
        check_val("step",   {28'd0, o_Cycle_Step}, exp_step);
        check_val("mcycle", {29'd0, o_M_Cycle}, 32'(mdl_m));
        check_val("opcode", {24'd0, o_Opcode}, {24'd0, mdl_op});
        check_val("start",  {31'd0, o_Instr_Start}, {31'd0, (mdl_start && !stall && !mdl_halted)});
        check_val("halted", {31'd0, o_Halted}, {31'd0, mdl_halted});
        check_val("fault",  {31'd0, o_Fault}, {31'd0, mdl_fault});
    endtask

    // One clock of specification behaviour, at the level of T index and counts.
    task automatic model_step(input bit stall, input bit rc, input logic [7:0] op,
                              input bit halt, input bit wake);
        if (mdl_halted) begin
            mdl_start = 0;
            if (!stall && wake) begin
                mdl_halted = 0; mdl_t = 0; mdl_m = 0; mdl_start = 1;
            end
        end else if (!stall) begin
            mdl_start = 0;
            if (mdl_t == 3) begin
                mdl_t = 0;
                if (rc) begin
                    mdl_op = op; mdl_m = 0;
                    if (c_HALT_EN && halt) mdl_halted = 1;
                    else mdl_start = 1;
                end else if (mdl_m == MAX_M - 1) begin
                    mdl_m = 0; mdl_op = op; mdl_fault = 1; mdl_start = 1;
                end else begin
                    mdl_m = mdl_m + 1;
                end
            end else begin
                if (rc) mdl_fault = 1;
                mdl_t = mdl_t + 1;
            end
        end
    endtask

    // Entered and left at posedge+1.
    task automatic run_cycle(input bit stall, input bit rc, input logic [7:0] op,
                             input bit halt, input bit wake);
        i_Stall = stall; i_Reset_Cycle = rc; i_Opcode_In = op; i_Halt = halt; i_Wake = wake;
        #4;
        compare_all(stall);
        @(posedge clk);
        model_step(stall, rc, op, halt, wake);
        #1;
    endtask

    // Asynchronous reset pulse between edges; the following edge is stalled so
    // the state shown right after release is the reset state.
    task automatic do_reset();
        i_Stall = 0; i_Reset_Cycle = 0; i_Halt = 0; i_Wake = 0;
        i_Reset = 1;
        #2;
        model_reset();
        compare_all(0);
        i_Stall = 1;
        i_Reset = 0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset();

        // NOP stream: end at every T4
        for (int i = 0; i < 12; i++) run_cycle(0, mdl_t == 3, 8'h00, 0, 0);

        // 3-M-cycle instruction with opcode 01, two rounds
        for (int i = 0; i < 24; i++) run_cycle(0, mdl_t == 3 && mdl_m == 2, 8'h01, 0, 0);

        // Stall for 3 clocks at T3 of M-cycle 1
        for (int i = 0; i < 16 && !(mdl_t == 2 && mdl_m == 1); i++)
            run_cycle(0, mdl_t == 3 && mdl_m == 2, 8'h02, 0, 0);
        for (int i = 0; i < 3; i++) run_cycle(1, 0, 8'h02, 0, 0);
        for (int i = 0; i < 6; i++) run_cycle(0, mdl_t == 3 && mdl_m == 2, 8'h02, 0, 0);

        // Longest legal instruction ends exactly on the watchdog boundary: no fault
        for (int i = 0; i < 30 && !(mdl_t == 0 && mdl_m == 0); i++)
            run_cycle(0, mdl_t == 3 && mdl_m == 2, 8'h03, 0, 0);
        for (int i = 0; i < 24; i++) run_cycle(0, mdl_t == 3 && mdl_m == MAX_M - 1, 8'h04, 0, 0);
        run_cycle(0, 0, 8'h05, 0, 0);

        // Watchdog: no end request at all
        for (int i = 0; i < 30; i++) run_cycle(0, 0, 8'h3C, 0, 0);

        // Protocol error: end request at step 0010
        do_reset();
        run_cycle(0, 0, 8'h00, 0, 0);
        run_cycle(0, 1, 8'h77, 0, 0);
        for (int i = 0; i < 6; i++) run_cycle(0, 0, 8'h00, 0, 0);

        // HALT entry with end request, wake 5 clocks later
        do_reset();
        for (int i = 0; i < 4 && mdl_t != 3; i++) run_cycle(0, 0, 8'h00, 0, 0);
        run_cycle(0, 1, 8'h76, 1, 0);
        for (int i = 0; i < 4; i++) run_cycle(0, 0, 8'h00, 0, 0);
        run_cycle(1, 0, 8'h00, 0, 1);   // stall outranks wake
        run_cycle(0, 0, 8'h00, 0, 1);
        for (int i = 0; i < 6; i++) run_cycle(0, mdl_t == 3, 8'h11, 0, 0);

        // Wake already high at entry still costs one halted cycle
        for (int i = 0; i < 4 && mdl_t != 3; i++) run_cycle(0, 0, 8'h00, 0, 1);
        run_cycle(0, 1, 8'h76, 1, 1);
        for (int i = 0; i < 3; i++) run_cycle(0, mdl_t == 3, 8'h22, 0, 1);

        // Randomized traffic with periodic resets
        for (int i = 0; i < 3000; i++) begin
            bit         st, rc, hl, wk;
            logic [7:0] op;
            if (i % 250 == 249) do_reset();
            st = ($urandom_range(0, 9) < 2);
            if (mdl_t == 3 && !mdl_halted) rc = ($urandom_range(0, 9) < 3);
            else rc = ($urandom_range(0, 99) < 2);
            hl = ($urandom_range(0, 9) < 3);
            wk = ($urandom_range(0, 9) < 3);
            op = 8'($urandom);
            run_cycle(st, rc, op, hl, wk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
